// File: rtl/tt_slot_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tt_slot_mux_pkg
// Brief    : Shared types and packed-bus field positions for the slot mux.
// Revision : 1.0 - initial release
// ============================================================================
package tt_slot_mux_pkg;

    // Hand-over sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_SWITCH  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_ACTIVE  = 3'd4
    } state_t;

    // Packed bus widths
    localparam int IW_W = 18;
    localparam int OW_W = 24;

    // iw = {uio_in, ui_in, rst_n, clk}
    localparam int IW_CLK     = 0;
    localparam int IW_RSTN    = 1;
    localparam int IW_UI_LSB  = 2;
    localparam int IW_UIO_LSB = 10;

    // ow = {uio_oe, uio_out, uo_out}
    localparam int OW_UO_LSB  = 0;
    localparam int OW_UIO_LSB = 8;
    localparam int OW_OE_LSB  = 16;

    // True when an address names an existing slot
    function automatic logic addr_in_range(input int addr, input int num_proj);
        return (addr < num_proj);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_slot_mux_seq.sv
`default_nettype none
// ============================================================================
// Module   : tt_slot_mux_seq
// Brief    : Select-command sequencer: quiesce -> switch -> held reset ->
//            active. Owns the pending/current slot address and the two
//            route flags (slot enabled, slot reset released).
// Revision : 1.0 - initial release
// ============================================================================
module tt_slot_mux_seq
    import tt_slot_mux_pkg::*;
#(
    parameter int NUM_PROJ   = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 2,
    parameter int RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sel_valid,
    input  logic [ADDR_W-1:0] i_sel_addr,
    output logic              o_sel_ready,
    output logic              o_sel_err,
    output logic              o_active,
    output logic [ADDR_W-1:0] o_cur_addr,
    output logic              o_route_ena,
    output logic              o_route_rel
);

    // One counter serves both timed phases; it only ever counts up to the
    // last cycle of the phase and then leaves, so it cannot wrap.
    localparam int c_CNT_MAX = (GAP_CYCLES > RST_CYCLES) ? GAP_CYCLES : RST_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(RST_CYCLES - 1);

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0]   r_pend;
    logic [ADDR_W-1:0]   r_cur;
    logic                r_ready;
    logic                r_err;
    logic                r_active;
    logic                r_ena;
    logic                r_rel;

    // Sequencer with all outputs registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_pend   <= '0;
            r_cur    <= '0;
            r_ready  <= 1'b1;
            r_err    <= 1'b0;
            r_active <= 1'b0;
            r_ena    <= 1'b0;
            r_rel    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_sel_valid) begin
                        r_pend  <= i_sel_addr;
                        r_ready <= 1'b0;
                        r_state <= ST_SWITCH;
                        // error flag lines up with the SWITCH cycle
                        r_err   <= !addr_in_range(int'(i_sel_addr), NUM_PROJ);
                    end
                end
                ST_ACTIVE: begin
                    if (i_sel_valid) begin
                        r_pend   <= i_sel_addr;
                        r_ready  <= 1'b0;
                        r_active <= 1'b0;
                        r_ena    <= 1'b0;
                        r_rel    <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= ST_QUIESCE;
                    end
                end
                ST_QUIESCE: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_state <= ST_SWITCH;
                        r_err   <= !addr_in_range(int'(r_pend), NUM_PROJ);
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_SWITCH: begin
                    if (!addr_in_range(int'(r_pend), NUM_PROJ)) begin
                        // bad address: drop back to idle, routing untouched
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cur   <= r_pend;
                        r_ena   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == c_RST_LAST) begin
                        r_rel    <= 1'b1;
                        r_active <= 1'b1;
                        r_ready  <= 1'b1;
                        r_state  <= ST_ACTIVE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_ready  <= 1'b1;
                    r_active <= 1'b0;
                    r_ena    <= 1'b0;
                    r_rel    <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_sel_ready = r_ready;
    assign o_sel_err   = r_err;
    assign o_active    = r_active;
    assign o_cur_addr  = r_cur;
    assign o_route_ena = r_ena;
    assign o_route_rel = r_rel;

endmodule
`default_nettype wire

// File: rtl/tt_slot_mux.sv
`default_nettype none
// ============================================================================
// Module   : tt_slot_mux
// Brief    : Hosts NUM_PROJ user-project slots behind one shared pad set.
//            Sequencing lives in tt_slot_mux_seq; this level only gates the
//            pad inputs into the selected slot and muxes its outputs back.
//            Optional macro TT_SLOT_MUX_OUTREG_EN registers the pad outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tt_slot_mux
    import tt_slot_mux_pkg::*;
#(
    parameter int NUM_PROJ   = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 2,
    parameter int RST_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel_valid,
    input  logic [ADDR_W-1:0]        sel_addr,
    output logic                     sel_ready,
    output logic                     sel_err,
    output logic                     active,
    output logic [ADDR_W-1:0]        cur_addr,
    input  logic                     pad_clk,
    input  logic                     pad_rst_n,
    input  logic [7:0]               pad_ui,
    input  logic [7:0]               pad_uio_in,
    output logic [7:0]               pad_uo_out,
    output logic [7:0]               pad_uio_out,
    output logic [7:0]               pad_uio_oe,
    output logic [NUM_PROJ-1:0]      slot_ena,
    output logic [NUM_PROJ*IW_W-1:0] slot_iw,
    input  logic [NUM_PROJ*OW_W-1:0] slot_ow
);

    logic                w_route_ena;
    logic                w_route_rel;
    logic [NUM_PROJ-1:0] w_slot_sel;
    logic [IW_W-1:0]     w_pad_iw;
    logic [OW_W-1:0]     w_ow_mux;

    tt_slot_mux_seq #(
        .NUM_PROJ   (NUM_PROJ),
        .ADDR_W     (ADDR_W),
        .GAP_CYCLES (GAP_CYCLES),
        .RST_CYCLES (RST_CYCLES)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .i_sel_valid (sel_valid),
        .i_sel_addr  (sel_addr),
        .o_sel_ready (sel_ready),
        .o_sel_err   (sel_err),
        .o_active    (active),
        .o_cur_addr  (cur_addr),
        .o_route_ena (w_route_ena),
        .o_route_rel (w_route_rel)
    );

    // Pad inputs packed into iw; rst_n held low until the release flag rises
    always_comb begin
        w_pad_iw                     = '0;
        w_pad_iw[IW_CLK]             = pad_clk;
        w_pad_iw[IW_RSTN]            = pad_rst_n & w_route_rel;
        w_pad_iw[IW_UI_LSB +: 8]     = pad_ui;
        w_pad_iw[IW_UIO_LSB +: 8]    = pad_uio_in;
    end

    // Per-slot gating: pad_clk reaches a slot only through AND gates driven
    // by registered flags, never through a flop of its own.
    for (genvar k = 0; k < NUM_PROJ; k++) begin : g_slot
        assign w_slot_sel[k]              = w_route_ena && (cur_addr == ADDR_W'(k));
        assign slot_ena[k]                = w_slot_sel[k];
        assign slot_iw[k*IW_W +: IW_W]    = w_pad_iw & {IW_W{w_slot_sel[k]}};
    end

    // AND-OR output mux; no slot selected gives all zeros
    always_comb begin
        w_ow_mux = '0;
        for (int k = 0; k < NUM_PROJ; k++) begin
            w_ow_mux = w_ow_mux | (slot_ow[k*OW_W +: OW_W] & {OW_W{w_slot_sel[k]}});
        end
    end

`ifdef TT_SLOT_MUX_OUTREG_EN
    logic [7:0] r_uo_out;
    logic [7:0] r_uio_out;
    logic [7:0] r_uio_oe;

    // Registered pad outputs: one clk of extra latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_uo_out  <= '0;
            r_uio_out <= '0;
            r_uio_oe  <= '0;
        end else begin
            r_uo_out  <= w_ow_mux[OW_UO_LSB  +: 8];
            r_uio_out <= w_ow_mux[OW_UIO_LSB +: 8];
            r_uio_oe  <= w_ow_mux[OW_OE_LSB  +: 8];
        end
    end

    assign pad_uo_out  = r_uo_out;
    assign pad_uio_out = r_uio_out;
    assign pad_uio_oe  = r_uio_oe;
`else
    assign pad_uo_out  = w_ow_mux[OW_UO_LSB  +: 8];
    assign pad_uio_out = w_ow_mux[OW_UIO_LSB +: 8];
    assign pad_uio_oe  = w_ow_mux[OW_OE_LSB  +: 8];
`endif

endmodule
`default_nettype wire
